decode_regfile: RTL

Parametrised decode-stage register file for the Y86 processor. It decodes `icode`/`rA`/`rB` into source register IDs and reads two operands into registered outputs, one cycle after the request. It also accepts two writeback ports, `E` (ALU result) and `M` (memory result), with deterministic priority. It replaces the sequential-only decode read and file-loaded register state with a resettable, stall-aware pipeline stage and optional same-cycle write-to-read forwarding.

---
 rtl/decode_regfile.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// Module   : decode_regfile
// Purpose  : Y86 decode-stage register file with registered, stall-aware
//            operand outputs and two prioritised writeback ports (M over E).
//            Optional same-cycle forwarding: define DECODE_REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_regfile #(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter int                RSP_IDX  = 4,
  parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              out_valid,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB
);

  localparam logic [3:0] c_none = 4'hF;
  localparam logic [4:0] c_nreg = 5'(NREG);
  localparam logic [3:0] c_rsp  = 4'(RSP_IDX);

  logic [DATA_W-1:0] regs_q [NREG];

  logic              out_valid_q, out_valid_d;
  logic [3:0]        srcA_q, srcA_d, srcB_q, srcB_d;
  logic [DATA_W-1:0] valA_q, valA_d, valB_q, valB_d;

  logic [3:0]        w_src_a, w_src_b;
  logic              w_we_e, w_we_m;

  function automatic logic id_ok(input logic [3:0] id);
    return (id != c_none) && ({1'b0, id} < c_nreg);
  endfunction

  assign w_we_e = id_ok(dstE);
  assign w_we_m = id_ok(dstM);

  // Register array; M is tested first so popq %rsp leaves the popped value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_we_m && dstM == 4'(i)) begin
          regs_q[i] <= valM;
        end else if (w_we_e && dstE == 4'(i)) begin
          regs_q[i] <= valE;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    if (id_ok(id)) begin
      for (int i = 0; i < NREG; i++) begin
        if (id == 4'(i)) begin
          v = regs_q[i];
        end
      end
`ifdef DECODE_REGFILE_BYPASS_EN
      if (w_we_e && dstE == id) begin
        v = valE;
      end
      if (w_we_m && dstM == id) begin
        v = valM;
      end
`endif
    end
    return v;
  endfunction

  always_comb begin
    w_src_a = c_none;
    w_src_b = c_none;
    case (icode)
      4'd2, 4'd4, 4'd6, 4'd10: w_src_a = rA;
      4'd9, 4'd11:             w_src_a = c_rsp;
      default:                 w_src_a = c_none;
    endcase
    case (icode)
      4'd4, 4'd5, 4'd6:              w_src_b = rB;
      4'd8, 4'd9, 4'd10, 4'd11:      w_src_b = c_rsp;
      default:                       w_src_b = c_none;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    srcA_d      = srcA_q;
    srcB_d      = srcB_q;
    valA_d      = valA_q;
    valB_d      = valB_q;
    // Held operands are deliberately not refreshed by writebacks during stall.
    if (!stall) begin
      out_valid_d = in_valid;
      if (in_valid) begin
        srcA_d = w_src_a;
        srcB_d = w_src_b;
        valA_d = read_reg(w_src_a);
        valB_d = read_reg(w_src_b);
      end else begin
        srcA_d = c_none;
        srcB_d = c_none;
        valA_d = '0;
        valB_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      srcA_q      <= c_none;
      srcB_q      <= c_none;
      valA_q      <= '0;
      valB_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      srcA_q      <= srcA_d;
      srcB_q      <= srcB_d;
      valA_q      <= valA_d;
      valB_q      <= valB_d;
    end
  end

  assign out_valid = out_valid_q;
  assign srcA      = srcA_q;
  assign srcB      = srcB_q;
  assign valA      = valA_q;
  assign valB      = valB_q;

endmodule
`default_nettype wire
